// File: rtl/riscv_multicycle_ctrl_if.sv
// Memory handshake bundle between the multi-cycle sequencer and memory.
//   mem_req      : request, held high until mem_ready
//   mem_we       : 1 = store request
//   mem_addr_sel : address mux select, 0 = PC, 1 = ALU result
//   mem_ready    : memory completes the current request this cycle
// master = sequencer side, slave = memory side.
interface riscv_multicycle_ctrl_if;
    logic mem_req;
    logic mem_we;
    logic mem_addr_sel;
    logic mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr_sel,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr_sel,
        output mem_ready
    );
endinterface

// File: rtl/riscv_multicycle_ctrl.sv
// Multi-cycle sequencer for the RV32I datapath. Steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB, drives datapath selects and strobes, counts retired
// instructions and traps illegal opcodes / branch conditions and memory timeouts.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   start               begin execution (only looked at in IDLE)
//   opcode, func3       IR fields (IR is stable from DECODE until the next FETCH)
//   alu_zero            ALU zero flag, used for BEQ/BNE in EXEC
//   mem                 memory handshake (master side)
//   ir_we, pc_we        IR / PC write strobes
//   pc_src              0 = ALU result (PC+4), 1 = branch/jump target adder
//   alu_op              00 add, 01 sub/compare, 10 use func fields
//   alu_src_a/alu_src_b ALU operand selects
//   reg_we, wb_sel      register write strobe and write-back source
//   busy, fault         not-IDLE indicator, sticky error (FAULT state)
//   instret             retired instruction count, wraps silently
module riscv_multicycle_ctrl #(
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [6:0]                 opcode,
    input  logic [2:0]                 func3,
    input  logic                       alu_zero,
    riscv_multicycle_ctrl_if.master    mem,
    output logic                       ir_we,
    output logic                       pc_we,
    output logic                       pc_src,
    output logic [1:0]                 alu_op,
    output logic                       alu_src_a,
    output logic [1:0]                 alu_src_b,
    output logic                       reg_we,
    output logic [1:0]                 wb_sel,
    output logic                       busy,
    output logic                       fault,
    output logic [CNT_W-1:0]           instret
);

    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [2:0] {
        IDLE, FETCH, DECODE, EXEC, MEM, WB, FAULT
    } state_t;

    state_t            state_q, state_d;
    logic [TO_W-1:0]   wait_cnt;
    logic              retire;
    logic              timed_out;
    logic              is_r, is_i, is_ld, is_st, is_br, is_jal;
    logic              br_ok, br_taken;

    assign is_r   = (opcode == OP_R);
    assign is_i   = (opcode == OP_I);
    assign is_ld  = (opcode == OP_LD);
    assign is_st  = (opcode == OP_ST);
    assign is_br  = (opcode == OP_BR);
    assign is_jal = (opcode == OP_JAL);

    assign br_ok    = (func3 == 3'b000) || (func3 == 3'b001);
    assign br_taken = (func3 == 3'b000) ? alu_zero : !alu_zero;

    // wait_cnt holds the number of wait cycles already spent; a further
    // not-ready cycle at TIMEOUT-1 is the last one allowed. mem_ready is
    // checked first, so it always completes the request.
    assign timed_out = (wait_cnt == TO_W'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            wait_cnt <= '0;
            instret  <= '0;
        end else begin
            state_q <= state_d;
            // Any state change clears the counter, so it is zero on entry
            // to FETCH and MEM.
            if ((state_q == FETCH || state_q == MEM) && !mem.mem_ready
                && state_d == state_q)
                wait_cnt <= wait_cnt + TO_W'(1);
            else
                wait_cnt <= '0;
            if (retire)
                instret <= instret + CNT_W'(1);
        end
    end

    always_comb begin
        state_d          = state_q;
        retire           = 1'b0;
        mem.mem_req      = 1'b0;
        mem.mem_we       = 1'b0;
        mem.mem_addr_sel = 1'b0;
        ir_we            = 1'b0;
        pc_we            = 1'b0;
        pc_src           = 1'b0;
        alu_op           = 2'b00;
        alu_src_a        = 1'b0;
        alu_src_b        = 2'b00;
        reg_we           = 1'b0;
        wb_sel           = 2'b00;
        busy             = 1'b1;
        fault            = 1'b0;

        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start)
                    state_d = FETCH;
            end
            FETCH: begin
                mem.mem_req = 1'b1;
                alu_src_b   = 2'b01;
                if (mem.mem_ready) begin
                    ir_we   = 1'b1;
                    pc_we   = 1'b1;
                    state_d = DECODE;
                end else if (timed_out) begin
                    state_d = FAULT;
                end
            end
            DECODE: begin
                if (is_r || is_i || is_ld || is_st || is_br || is_jal)
                    state_d = EXEC;
                else
                    state_d = FAULT;
            end
            EXEC: begin
                if (is_r) begin
                    alu_op    = 2'b10;
                    alu_src_a = 1'b1;
                    state_d   = WB;
                end else if (is_i) begin
                    alu_op    = 2'b10;
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    state_d   = WB;
                end else if (is_ld || is_st) begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    state_d   = MEM;
                end else if (is_br) begin
                    alu_op    = 2'b01;
                    alu_src_a = 1'b1;
                    if (br_ok) begin
                        pc_we   = br_taken;
                        pc_src  = br_taken;
                        retire  = 1'b1;
                        state_d = FETCH;
                    end else begin
                        state_d = FAULT;
                    end
                end else if (is_jal) begin
                    pc_we   = 1'b1;
                    pc_src  = 1'b1;
                    state_d = WB;
                end else begin
                    state_d = FAULT;
                end
            end
            MEM: begin
                mem.mem_req      = 1'b1;
                mem.mem_addr_sel = 1'b1;
                mem.mem_we       = is_st;
                alu_src_a        = 1'b1;
                alu_src_b        = 2'b10;
                if (mem.mem_ready) begin
                    if (is_st) begin
                        retire  = 1'b1;
                        state_d = FETCH;
                    end else begin
                        state_d = WB;
                    end
                end else if (timed_out) begin
                    state_d = FAULT;
                end
            end
            WB: begin
                reg_we  = 1'b1;
                wb_sel  = is_ld ? 2'b01 : (is_jal ? 2'b10 : 2'b00);
                retire  = 1'b1;
                state_d = FETCH;
            end
            FAULT: begin
                fault = 1'b1;
            end
            default: begin
                state_d = FAULT;
            end
        endcase
    end

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Directed bench for riscv_multicycle_ctrl (CNT_W=4 so wrap is reachable,
// TIMEOUT=4). Outputs are packed into one vector and compared per cycle
// against hand-written per-state patterns.
module tb_riscv_multicycle_ctrl;

    // {mem_req,mem_we,mem_addr_sel}_{ir_we,pc_we,pc_src}_alu_op_src_a_src_b_reg_we_wb_sel_{busy,fault}
    localparam logic [15:0] O_IDLE    = 16'b000_000_00_0_00_0_00_00;
    localparam logic [15:0] O_FETCH_W = 16'b100_000_00_0_01_0_00_10;
    localparam logic [15:0] O_FETCH_R = 16'b100_110_00_0_01_0_00_10;
    localparam logic [15:0] O_DECODE  = 16'b000_000_00_0_00_0_00_10;
    localparam logic [15:0] O_EXEC_R  = 16'b000_000_10_1_00_0_00_10;
    localparam logic [15:0] O_EXEC_I  = 16'b000_000_10_1_10_0_00_10;
    localparam logic [15:0] O_EXEC_M  = 16'b000_000_00_1_10_0_00_10;
    localparam logic [15:0] O_EXEC_BT = 16'b000_011_01_1_00_0_00_10;
    localparam logic [15:0] O_EXEC_BN = 16'b000_000_01_1_00_0_00_10;
    localparam logic [15:0] O_EXEC_J  = 16'b000_011_00_0_00_0_00_10;
    localparam logic [15:0] O_MEM_LD  = 16'b101_000_00_1_10_0_00_10;
    localparam logic [15:0] O_MEM_ST  = 16'b111_000_00_1_10_0_00_10;
    localparam logic [15:0] O_WB_ALU  = 16'b000_000_00_0_00_1_00_10;
    localparam logic [15:0] O_WB_LD   = 16'b000_000_00_0_00_1_01_10;
    localparam logic [15:0] O_WB_J    = 16'b000_000_00_0_00_1_10_10;
    localparam logic [15:0] O_FAULT   = 16'b000_000_00_0_00_0_00_11;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    logic        clk = 1'b0;
    logic        rst_n, start, alu_zero;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic        ir_we, pc_we, pc_src, alu_src_a, reg_we, busy, fault;
    logic [1:0]  alu_op, alu_src_b, wb_sel;
    logic [3:0]  instret;
    logic [15:0] outs;

    int          checks = 0;
    int          errors = 0;
    logic [3:0]  exp_ret = '0;

    always #5 clk = ~clk;

    riscv_multicycle_ctrl_if bus ();

    riscv_multicycle_ctrl #(.CNT_W(4), .TIMEOUT(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .opcode    (opcode),
        .func3     (func3),
        .alu_zero  (alu_zero),
        .mem       (bus.master),
        .ir_we     (ir_we),
        .pc_we     (pc_we),
        .pc_src    (pc_src),
        .alu_op    (alu_op),
        .alu_src_a (alu_src_a),
        .alu_src_b (alu_src_b),
        .reg_we    (reg_we),
        .wb_sel    (wb_sel),
        .busy      (busy),
        .fault     (fault),
        .instret   (instret)
    );

    assign outs = {bus.mem_req, bus.mem_we, bus.mem_addr_sel, ir_we, pc_we, pc_src,
                   alu_op, alu_src_a, alu_src_b, reg_we, wb_sel, busy, fault};

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b1; bus.mem_ready = 1'b1;
        opcode = OP_R; func3 = 3'b000; alu_zero = 1'b0;
        tick(); tick();
        #1;
        checks++;
        if (outs !== O_IDLE) begin errors++; $display("FAIL reset_outs got=%b exp=%b", outs, O_IDLE); end
        checks++;
        if (instret !== 4'd0) begin errors++; $display("FAIL reset_instret got=%0d exp=0", instret); end
        start = 1'b0; rst_n = 1'b1;
        tick();
    endtask

    // R, I and JAL share the FETCH-DECODE-EXEC-WB path.
    task automatic test_alu_jal;
        logic [6:0]  ops [3] = '{OP_R, OP_I, OP_JAL};
        logic [15:0] ex  [3] = '{O_EXEC_R, O_EXEC_I, O_EXEC_J};
        logic [15:0] wb  [3] = '{O_WB_ALU, O_WB_ALU, O_WB_J};
        logic [15:0] seq [4];
        bus.mem_ready = 1'b1;
        opcode = OP_R;
        start = 1'b1;
        #1;
        checks++;
        if (outs !== O_IDLE) begin errors++; $display("FAIL idle_start got=%b exp=%b", outs, O_IDLE); end
        tick();
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            opcode = ops[k];
            seq = '{O_FETCH_R, O_DECODE, ex[k], wb[k]};
            for (int c = 0; c < 4; c++) begin
                #1;
                checks++;
                if (outs !== seq[c]) begin
                    errors++;
                    $display("FAIL alu_jal op=%b cyc=%0d got=%b exp=%b", ops[k], c, outs, seq[c]);
                end
                if (c == 3) begin
                    checks++;
                    if (instret !== exp_ret) begin errors++; $display("FAIL wb_instret got=%0d exp=%0d", instret, exp_ret); end
                end
                tick();
            end
            exp_ret++;
            checks++;
            if (instret !== exp_ret) begin errors++; $display("FAIL alu_jal_instret got=%0d exp=%0d", instret, exp_ret); end
        end
    endtask

    // Load and store with three not-ready cycles in MEM (one short of TIMEOUT).
    task automatic test_mem;
        for (int k = 0; k < 2; k++) begin
            logic [15:0] m_exp;
            opcode = (k == 0) ? OP_LD : OP_ST;
            m_exp  = (k == 0) ? O_MEM_LD : O_MEM_ST;
            bus.mem_ready = 1'b1;
            #1;
            checks++;
            if (outs !== O_FETCH_R) begin errors++; $display("FAIL mem_fetch k=%0d got=%b exp=%b", k, outs, O_FETCH_R); end
            tick(); #1;
            checks++;
            if (outs !== O_DECODE) begin errors++; $display("FAIL mem_decode k=%0d got=%b exp=%b", k, outs, O_DECODE); end
            tick(); #1;
            checks++;
            if (outs !== O_EXEC_M) begin errors++; $display("FAIL mem_exec k=%0d got=%b exp=%b", k, outs, O_EXEC_M); end
            tick();
            for (int c = 0; c < 4; c++) begin
                bus.mem_ready = (c == 3);
                #1;
                checks++;
                if (outs !== m_exp) begin errors++; $display("FAIL mem_hold k=%0d cyc=%0d got=%b exp=%b", k, c, outs, m_exp); end
                tick();
            end
            bus.mem_ready = 1'b1;
            if (k == 0) begin
                #1;
                checks++;
                if (outs !== O_WB_LD) begin errors++; $display("FAIL ld_wb got=%b exp=%b", outs, O_WB_LD); end
                tick();
            end
            exp_ret++;
            #1;
            checks++;
            if (outs !== O_FETCH_R) begin errors++; $display("FAIL mem_refetch k=%0d got=%b exp=%b", k, outs, O_FETCH_R); end
            checks++;
            if (instret !== exp_ret) begin errors++; $display("FAIL mem_instret k=%0d got=%0d exp=%0d", k, instret, exp_ret); end
        end
    endtask

    task automatic test_branch;
        logic [2:0]  f3 [4] = '{3'b000, 3'b000, 3'b001, 3'b001};
        logic        z  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [15:0] ex [4] = '{O_EXEC_BT, O_EXEC_BN, O_EXEC_BT, O_EXEC_BN};
        opcode = OP_BR;
        bus.mem_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            func3 = f3[k]; alu_zero = z[k];
            tick(); tick(); #1;
            checks++;
            if (outs !== ex[k]) begin errors++; $display("FAIL br_exec k=%0d got=%b exp=%b", k, outs, ex[k]); end
            tick();
            exp_ret++;
            #1;
            checks++;
            if (outs !== O_FETCH_R || instret !== exp_ret) begin
                errors++;
                $display("FAIL br_refetch k=%0d got=%b/%0d exp=%b/%0d", k, outs, instret, O_FETCH_R, exp_ret);
            end
        end
    endtask

    task automatic test_wrap;
        opcode = OP_BR; func3 = 3'b000; alu_zero = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick(); tick(); tick();
            exp_ret++;
            checks++;
            if (instret !== exp_ret) begin errors++; $display("FAIL wrap k=%0d got=%0d exp=%0d", k, instret, exp_ret); end
        end
    endtask

    task automatic test_timeout;
        bus.mem_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++;
            if (outs !== O_FETCH_W) begin errors++; $display("FAIL to_wait cyc=%0d got=%b exp=%b", c, outs, O_FETCH_W); end
            tick();
        end
        for (int c = 0; c < 3; c++) begin
            start = (c != 1);
            #1;
            checks++;
            if (outs !== O_FAULT) begin errors++; $display("FAIL fault_sticky cyc=%0d got=%b exp=%b", c, outs, O_FAULT); end
            tick();
        end
        start = 1'b0; rst_n = 1'b0;
        tick();
        rst_n = 1'b1; exp_ret = '0;
        #1;
        checks++;
        if (outs !== O_IDLE || instret !== 4'd0) begin
            errors++;
            $display("FAIL fault_reset got=%b/%0d exp=%b/0", outs, instret, O_IDLE);
        end
    endtask

    task automatic test_illegal;
        for (int k = 0; k < 2; k++) begin
            opcode = (k == 0) ? 7'b0000000 : OP_BR;
            func3 = 3'b100; alu_zero = 1'b1; bus.mem_ready = 1'b1;
            start = 1'b1;
            tick();
            start = 1'b0;
            tick(); #1;
            checks++;
            if (outs !== O_DECODE) begin errors++; $display("FAIL ill_decode k=%0d got=%b exp=%b", k, outs, O_DECODE); end
            tick();
            if (k == 1) begin
                #1;
                checks++;
                if (outs !== O_EXEC_BN) begin errors++; $display("FAIL ill_br_exec got=%b exp=%b", outs, O_EXEC_BN); end
                tick();
            end
            #1;
            checks++;
            if (outs !== O_FAULT || instret !== 4'd0) begin
                errors++;
                $display("FAIL ill_fault k=%0d got=%b/%0d exp=%b/0", k, outs, instret, O_FAULT);
            end
            rst_n = 1'b0;
            tick();
            rst_n = 1'b1;
        end
    endtask

    task automatic test_reset_mem;
        opcode = OP_LD; bus.mem_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        bus.mem_ready = 1'b0;
        #1;
        checks++;
        if (outs !== O_MEM_LD) begin errors++; $display("FAIL rm_mem got=%b exp=%b", outs, O_MEM_LD); end
        rst_n = 1'b0;
        tick();
        checks++;
        if (outs !== O_IDLE || instret !== 4'd0) begin
            errors++;
            $display("FAIL rm_reset got=%b/%0d exp=%b/0", outs, instret, O_IDLE);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (outs !== O_IDLE) begin errors++; $display("FAIL rm_idle got=%b exp=%b", outs, O_IDLE); end
    endtask

    initial begin
        test_reset();
        test_alu_jal();
        test_mem();
        test_branch();
        test_wrap();
        test_timeout();
        test_illegal();
        test_reset_mem();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
